scan_loader: RTL and testbench

SCAN_LOADER -- requirements
Module: scan_loader

---
 rtl/scan_loader.sv | 154 +++++++++++++++
 tb/tb_scan_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : scan_loader
// Desc   : Loads a scan chain from a byte stream, MSB first, 8 shifts per byte.
//          Define SCAN_LOADER_READBACK_EN to capture chain output into out_data.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module scan_loader #(
  parameter int CHAIN_LEN = 272,
  parameter int BYTES     = CHAIN_LEN / 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       scan_enable,
  output logic       scan_out,
  input  logic       scan_in,
  output logic       busy,
  output logic       done
);

  localparam int               CNT_W    = $clog2(BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
`ifdef SCAN_LOADER_READBACK_EN
    DRAIN = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             in_ready_q;
  logic             scan_en_q;
  logic             busy_q;
  logic             done_q;

`ifdef SCAN_LOADER_READBACK_EN
  logic [7:0]       cap_q, cap_d;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
`ifdef SCAN_LOADER_READBACK_EN
    cap_d   = cap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // data_q[7] drives scan_out; shifting left presents the next bit
        data_d = {data_q[6:0], 1'b0};
`ifdef SCAN_LOADER_READBACK_EN
        cap_d  = {cap_q[6:0], scan_in};
`endif
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SCAN_LOADER_READBACK_EN
          state_d = DRAIN;
`else
          state_d = (cnt_d == LAST_CNT) ? DONE : LOAD;
`endif
        end
      end
`ifdef SCAN_LOADER_READBACK_EN
      DRAIN: begin
        if (out_ready) state_d = (cnt_q == LAST_CNT) ? DONE : LOAD;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCAN_LOADER_READBACK_EN
      cap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      in_ready_q  <= (state_d == LOAD);
      scan_en_q   <= (state_d == SHIFT);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
`ifdef SCAN_LOADER_READBACK_EN
      cap_q       <= cap_d;
      out_valid_q <= (state_d == DRAIN);
      out_data_q  <= (state_d == DRAIN) ? cap_d : 8'h00;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign scan_enable = scan_en_q;
  assign scan_out    = data_q[7];
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef SCAN_LOADER_READBACK_EN
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`else
  logic unused_inputs;
  assign unused_inputs = scan_in ^ out_ready;
  assign out_valid     = 1'b0;
  assign out_data      = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_loader.sv
`timescale 1ns/1ps
// Bench for scan_loader: chain model on the scan pins, scoreboard queues for
// shifted bits and readback bytes, pass-length and reset checks.
module tb_scan_loader;
  localparam int CL = 272;
  localparam int NB = CL / 8;
`ifdef SCAN_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int PER_BYTE = RB ? 10 : 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid, scan_enable, scan_out, scan_in, busy, done;
  logic [7:0] out_data;

  logic       s_start = 1'b0, s_in_valid = 1'b0;
  logic [7:0] s_in_data = 8'h00;
  logic       s_in_ready, s_out_valid, s_scan_enable, s_scan_out, s_busy, s_done;
  logic [7:0] s_out_data;

  scan_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .scan_enable(scan_enable), .scan_out(scan_out), .scan_in(scan_in), .busy(busy), .done(done)
  );

  scan_loader #(.CHAIN_LEN(8)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .scan_enable(s_scan_enable), .scan_out(s_scan_out), .scan_in(1'b0), .busy(s_busy), .done(s_done)
  );

  // Scan chain: a CL-bit shift register, first bit in is first bit out
  logic [CL-1:0] chain_q;
  logic          preload = 1'b0;
  logic [CL-1:0] preload_val = '0;
  assign scan_in = chain_q[CL-1];
  always @(posedge clk) begin
    if (preload) chain_q <= preload_val;
    else if (scan_enable) chain_q <= {chain_q[CL-2:0], scan_out};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vectors = 0, miscompares = 0;
  logic       exp_bits[$];
  logic [7:0] exp_rb[$];
  int         done_cnt = 0, rb_idx = 0;
  int         out_stall_at = -1, out_stall_n = 0, sink_cnt = 0;
  logic [7:0] model[NB];
  logic [7:0] pass_data[NB];
  int         in_stall[NB];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shifts or presents a byte
  always @(negedge clk) begin : mon
    logic       e;
    logic [7:0] eb;
    if (scan_enable) begin
      if (exp_bits.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scan_out_unexpected: shift with scan_out=%0b, none expected", scan_out);
      end else begin
        e = exp_bits.pop_front();
        check("scan_out", int'(scan_out), int'(e));
      end
    end
    if (out_valid && out_ready) begin
      if (exp_rb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL out_data_unexpected: got %02h, none expected", out_data);
      end else begin
        eb = exp_rb.pop_front();
        check("out_data", int'(out_data), int'(eb));
      end
      rb_idx++;
    end
    if (done) done_cnt++;
  end

  // Readback sink: holds out_ready low for out_stall_n cycles on one chosen byte
  always @(posedge clk) begin : sink
    #1;
    if (out_valid && rb_idx == out_stall_at && sink_cnt < out_stall_n) begin
      out_ready = 1'b0;
      sink_cnt++;
    end else begin
      out_ready = 1'b1;
      if (rb_idx != out_stall_at) sink_cnt = 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic preload_chain();
    for (int k = 0; k < NB; k++) begin
      model[k] = 8'($urandom);
      preload_val[CL-1-8*k -: 8] = model[k];
    end
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
  endtask

  task automatic send_byte(input int k, output bit ok);
    int tmo = 0;
    ok = 1'b1;
    while (!in_ready && tmo < 100) begin @(posedge clk); #1; tmo++; end
    if (!in_ready) begin
      check("in_ready_timeout", int'(in_ready), 1);
      ok = 1'b0;
      return;
    end
    repeat (in_stall[k]) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = pass_data[k];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_pass(input int ob, input int on, input bit glitch);
    int t0, exp_len, dc0, tmo;
    bit ok;
    exp_len = NB * PER_BYTE;
    for (int k = 0; k < NB; k++) begin
      for (int b = 7; b >= 0; b--) exp_bits.push_back(pass_data[k][b]);
      exp_len += in_stall[k];
    end
    if (RB) begin
      for (int k = 0; k < NB; k++) exp_rb.push_back(model[k]);
      exp_len += on;
    end
    model        = pass_data;
    out_stall_at = rb_idx + ob;
    out_stall_n  = on;
    dc0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < NB; k++) begin
      send_byte(k, ok);
      if (!ok) break;
      if (glitch && k == 5) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    tmo = 0;
    while (!done && tmo < 200) begin @(posedge clk); #1; tmo++; end
    check("pass_len", cyc - t0, exp_len);
    @(posedge clk); #1;
    check("busy_after_done", int'(busy), 0);
    repeat (2) @(posedge clk); #1;
    check("done_pulses", done_cnt - dc0, 1);
    check("bits_left", exp_bits.size(), 0);
    check("rb_left", exp_rb.size(), 0);
    exp_bits.delete();
    exp_rb.delete();
  endtask

  task automatic reset_mid_pass();
    int dc0;
    bit ok;
    for (int k = 0; k < NB; k++) begin pass_data[k] = 8'($urandom); in_stall[k] = 0; end
    for (int k = 0; k <= 10; k++)
      for (int b = 7; b >= 0; b--) exp_bits.push_back(pass_data[k][b]);
    if (RB) for (int k = 0; k < 10; k++) exp_rb.push_back(model[k]);
    dc0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      send_byte(k, ok);
      if (!ok) break;
    end
    repeat (3) @(posedge clk); #1;
    check("rst_in_shift", int'(scan_enable), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_scan_enable", int'(scan_enable), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_bits_left", exp_bits.size(), 4);
    repeat (6) @(posedge clk); #1;
    check("rst_no_done", done_cnt - dc0, 0);
    check("rst_still_idle", int'(busy), 0);
    check("rst_rb_left", exp_rb.size(), 0);
    exp_bits.delete();
    exp_rb.delete();
    preload_chain();
  endtask

  task automatic small_pass();
    logic [7:0] got = 8'h00;
    int nb = 0, t0, lat = 0;
    bit seen = 1'b0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    t0 = cyc;
    check("small_in_ready", int'(s_in_ready), 1);
    s_in_valid = 1'b1;
    s_in_data  = 8'hA5;
    @(posedge clk); #1 s_in_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_scan_enable) begin got = {got[6:0], s_scan_out}; nb++; end
      if (s_done) begin seen = 1'b1; lat = cyc - t0; end
    end
    check("small_bits", int'(got), 32'hA5);
    check("small_nbits", nb, 8);
    check("small_done_seen", int'(seen), 1);
    check("small_latency", lat, PER_BYTE);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_scan_enable", int'(scan_enable), 0);
    check("reset_scan_out", int'(scan_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    preload_chain();

    for (int k = 0; k < NB; k++) begin pass_data[k] = 8'(k); in_stall[k] = 0; end
    run_pass(0, 0, 1'b0);

    for (int k = 0; k < NB; k++) pass_data[k] = 8'hFF;
    run_pass(0, 0, 1'b0);

    for (int k = 0; k < NB; k++) begin pass_data[k] = 8'($urandom); in_stall[k] = 0; end
    in_stall[3] = 5;
    run_pass(7, 4, 1'b0);

    for (int k = 0; k < NB; k++) begin pass_data[k] = 8'($urandom); in_stall[k] = 0; end
    run_pass(0, 0, 1'b1);

    reset_mid_pass();

    repeat (3) begin
      for (int k = 0; k < NB; k++) begin
        pass_data[k] = 8'($urandom);
        in_stall[k]  = int'($urandom_range(0, 2));
      end
      run_pass(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 5)), 1'b0);
    end

    small_pass();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
